// File: rtl/kernel_mac_pipe.sv
// kernel_mac_pipe: parametrised pipelined multiply-accumulate.
//   Sample path: stage 1 registers the operands, stage 2 forms the full
//   A_WIDTH+B_WIDTH product, and stages 3..NUM_STAGE only delay it.
//   dout is that product resized to P_WIDTH.
//   An optional accumulator stage sits after the product pipeline. It sums
//   ext(dout), honours an in-band clear and keeps a sticky overflow flag.
// Ports:
//   clk, reset (async, active low), ce (freezes every register when 0)
//   in_valid, din0, din1, acc_clr   sample inputs; acc_clr travels with its sample
//   out_valid, dout                  product output, NUM_STAGE ce cycles after input
//   acc_valid, acc, ovf              accumulator output, one ce cycle after dout
module kernel_mac_pipe #(
   parameter int A_WIDTH   = 10,
   parameter int B_WIDTH   = 11,
   parameter int P_WIDTH   = 20,
   parameter int ACC_WIDTH = 32,
   parameter int NUM_STAGE = 4,
   parameter int SIGNED    = 0,
   parameter int ACC_EN    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   input  logic                 in_valid,
   input  logic [A_WIDTH-1:0]   din0,
   input  logic [B_WIDTH-1:0]   din1,
   input  logic                 acc_clr,
   output logic                 out_valid,
   output logic [P_WIDTH-1:0]   dout,
   output logic                 acc_valid,
   output logic [ACC_WIDTH-1:0] acc,
   output logic                 ovf
);

   localparam int FULL = A_WIDTH + B_WIDTH;

   // vld_pipe[i-1] is the valid bit of stage i. The top bit, vld_pipe[NUM_STAGE],
   // is the valid bit of the accumulator stage.
   logic [NUM_STAGE:0]            vld_pipe;
   logic [NUM_STAGE-1:0]          clr_pipe;
   logic [A_WIDTH-1:0]            a_q;
   logic [B_WIDTH-1:0]            b_q;
   logic [NUM_STAGE:2][FULL-1:0]  prod_pipe;

   // Extend both operands to the full product width before multiplying.
   // The low FULL bits of the product of the extended operands are then the
   // correct two's complement (or unsigned) result.
   logic              a_sgn, b_sgn;
   logic [FULL-1:0]   a_ext, b_ext, mult;

   assign a_sgn = (SIGNED != 0) && a_q[A_WIDTH-1];
   assign b_sgn = (SIGNED != 0) && b_q[B_WIDTH-1];
   assign a_ext = {{B_WIDTH{a_sgn}}, a_q};
   assign b_ext = {{A_WIDTH{b_sgn}}, b_q};
   assign mult  = a_ext * b_ext;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe  <= '0;
         clr_pipe  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         prod_pipe <= '0;
      end else if (ce) begin
         vld_pipe     <= {vld_pipe[NUM_STAGE-1:0], in_valid};
         clr_pipe     <= {clr_pipe[NUM_STAGE-2:0], acc_clr};
         a_q          <= din0;
         b_q          <= din1;
         prod_pipe[2] <= mult;
         for (int i = 3; i <= NUM_STAGE; i++)
            prod_pipe[i] <= prod_pipe[i-1];
      end
   end

   // Size casts truncate (wrap) or extend. A signed source extends with its
   // sign bit, so one cast covers both P_WIDTH < FULL and P_WIDTH > FULL.
   generate
      if (SIGNED != 0) begin : g_dout_s
         assign dout = P_WIDTH'($signed(prod_pipe[NUM_STAGE]));
      end else begin : g_dout_u
         assign dout = P_WIDTH'(prod_pipe[NUM_STAGE]);
      end
   endgenerate

   assign out_valid = vld_pipe[NUM_STAGE-1];

   generate
      if (ACC_EN != 0) begin : g_acc
         logic [ACC_WIDTH-1:0] acc_q, addend;
         logic [ACC_WIDTH:0]   sum;
         logic                 ovf_q, add_ovf;
         logic                 vld_fin, clr_fin;

         assign vld_fin = vld_pipe[NUM_STAGE-1];
         assign clr_fin = clr_pipe[NUM_STAGE-1];

         if (SIGNED != 0) begin : g_ext_s
            assign addend  = ACC_WIDTH'($signed(dout));
            assign sum     = {1'b0, acc_q} + {1'b0, addend};
            // Operands of equal sign giving a result of the other sign.
            assign add_ovf = (acc_q[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                             (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]) &&
                             (sum[ACC_WIDTH] | 1'b1);
         end else begin : g_ext_u
            assign addend  = ACC_WIDTH'(dout);
            assign sum     = {1'b0, acc_q} + {1'b0, addend};
            assign add_ovf = sum[ACC_WIDTH];
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               acc_q <= '0;
               ovf_q <= 1'b0;
            end else if (ce) begin
               if (clr_fin) begin
                  // A clear restarts the sum. A valid sample becomes the new
                  // sum, and a bubble leaves zero. Overflow is never flagged here.
                  acc_q <= vld_fin ? addend : '0;
                  ovf_q <= 1'b0;
               end else if (vld_fin) begin
                  acc_q <= sum[ACC_WIDTH-1:0];
                  ovf_q <= ovf_q | add_ovf;
               end
            end
         end

         assign acc       = acc_q;
         assign ovf       = ovf_q;
         assign acc_valid = vld_pipe[NUM_STAGE];
      end else begin : g_no_acc
         assign acc       = '0;
         assign ovf       = 1'b0;
         assign acc_valid = 1'b0;
      end
   endgenerate

endmodule
